echo_test_driver: RTL and testbench



---
 rtl/echo_test_pkg.sv | 23 ++
 rtl/echo_test_patgen.sv | 47 ++++
 rtl/echo_test_driver.sv | 163 ++++++++++++++++
 tb/tb_echo_test_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_test_pkg.sv
// echo_test_pkg: shared types and helpers for the echo test driver.
//   state_e   - driver FSM states
//   sat_inc   - saturating increment, usable for any counter width <= 64
package echo_test_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter of width w held in the low bits of v; sticks at all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] maxv;
    maxv = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= maxv) ? maxv : v + 64'd1;
  endfunction

endpackage

// File: rtl/echo_test_patgen.sv
// echo_test_patgen: arithmetic sequence generator (base, base+step, ...).
//   clk, rst_n - clock, async active-low reset
//   load       - capture base/step; val becomes base next cycle
//   base, step - sequence start and increment
//   adv        - advance val by step (ignored while load is high)
//   val        - current sequence value, wraps mod 2^WIDTH
module echo_test_patgen
  import echo_test_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] step,
  input  logic             adv,
  output logic [WIDTH-1:0] val
);

  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] step_q, step_d;

  always_comb begin
    val_d  = val_q;
    step_d = step_q;
    if (load) begin
      val_d  = base;
      step_d = step;
    end else if (adv) begin
      val_d = val_q + step_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q  <= '0;
      step_q <= '0;
    end else begin
      val_q  <= val_d;
      step_q <= step_d;
    end
  end

  assign val = val_q;

endmodule

// File: rtl/echo_test_driver.sv
// echo_test_driver: streams base, base+step, ... into an echo block and
// checks the echoed indications, with a bounded in-flight window.
//   CLK, nRST            - clock, async active-low reset
//   start__ENA/RDY       - start command handshake (count/base/step)
//   enq__ENA/RDY, enq_v  - enqueue toward echo
//   ind__ENA/RDY, ind_v  - echoed indication from echo
//   done                 - one-cycle pulse on entering DONE
//   timed_out            - last run ended by the drain timeout
//   err_count            - mismatches + unsolicited indications (saturating)
//   recv_count           - indications accepted in current/last run
module echo_test_driver
  import echo_test_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start__ENA,
  output logic             start__RDY,
  input  logic [CNT_W-1:0] start_count,
  input  logic [WIDTH-1:0] start_base,
  input  logic [WIDTH-1:0] start_step,
  output logic             enq__ENA,
  output logic [WIDTH-1:0] enq_v,
  input  logic             enq__RDY,
  input  logic             ind__ENA,
  input  logic [WIDTH-1:0] ind_v,
  output logic             ind__RDY,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] recv_count
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic [CNT_W-1:0] recv_q, recv_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             to_q, to_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] next_val, exp_val;
  logic             start_acc, fire, ind_acc, solicited, err_inc, active;

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign start__RDY = (state_q == IDLE) || (state_q == DONE);
  assign ind__RDY   = active;
  assign start_acc  = start__ENA & start__RDY;

  // Depends on flops only, so no path from the indication side.
  assign enq__ENA   = (state_q == RUN) && (sent_q < count_q) &&
                      (out_q < OUT_W'(MAX_OUT));
  assign fire       = enq__ENA & enq__RDY;
  assign ind_acc    = ind__ENA & ind__RDY;
  // An indication with nothing outstanding is an error but must not
  // advance the expected sequence or the receive count.
  assign solicited  = ind_acc && (out_q != '0);
  assign err_inc    = ind_acc && (!solicited || (ind_v != exp_val));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sent_d  = sent_q;
    recv_d  = recv_q;
    err_d   = err_q;
    out_d   = out_q;
    tmr_d   = tmr_q;
    to_d    = to_q;
    done_d  = 1'b0;

    if (start_acc) begin
      count_d = start_count;
      sent_d  = '0;
      recv_d  = '0;
      err_d   = '0;
      out_d   = '0;
      tmr_d   = '0;
      to_d    = 1'b0;
      if (start_count == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (active) begin
      if (fire)      sent_d = sent_q + CNT_W'(1);
      if (solicited) recv_d = recv_q + CNT_W'(1);
      case ({fire, solicited})
        2'b10:   out_d = out_q + OUT_W'(1);
        2'b01:   out_d = out_q - OUT_W'(1);
        default: out_d = out_q;
      endcase
      if (err_inc) err_d = CNT_W'(sat_inc(64'(err_q), CNT_W));
      // Drain timer measures silence: any accepted indication restarts it.
      if (ind_acc)                tmr_d = '0;
      else if (state_q == DRAIN)  tmr_d = tmr_q + TMR_W'(1);

      if (solicited && (recv_d == count_q)) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else if ((state_q == DRAIN) && !ind_acc &&
                   (tmr_q == TMR_W'(TIMEOUT - 1))) begin
        state_d = DONE;
        to_d    = 1'b1;
        done_d  = 1'b1;
      end else if ((state_q == RUN) && fire && (sent_d == count_q)) begin
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      count_q <= '0;
      sent_q  <= '0;
      recv_q  <= '0;
      err_q   <= '0;
      out_q   <= '0;
      tmr_q   <= '0;
      to_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sent_q  <= sent_d;
      recv_q  <= recv_d;
      err_q   <= err_d;
      out_q   <= out_d;
      tmr_q   <= tmr_d;
      to_q    <= to_d;
      done_q  <= done_d;
    end
  end

  // Send side walks the sequence on each enqueue, check side on each
  // solicited indication; both reload on start.
  echo_test_patgen #(.WIDTH(WIDTH)) u_send (
    .clk(CLK), .rst_n(nRST), .load(start_acc), .base(start_base),
    .step(start_step), .adv(fire), .val(next_val)
  );

  echo_test_patgen #(.WIDTH(WIDTH)) u_check (
    .clk(CLK), .rst_n(nRST), .load(start_acc), .base(start_base),
    .step(start_step), .adv(solicited), .val(exp_val)
  );

  assign enq_v      = next_val;
  assign done       = done_q;
  assign timed_out  = to_q;
  assign err_count  = err_q;
  assign recv_count = recv_q;

endmodule

// File: tb/tb_echo_test_driver.sv
module tb_echo_test_driver;

  localparam int WIDTH   = 32;
  localparam int CNT_W   = 16;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 16;

  logic             CLK = 1'b0;
  logic             nRST = 1'b1;
  logic             start__ENA = 1'b0;
  logic             start__RDY;
  logic [CNT_W-1:0] start_count = '0;
  logic [WIDTH-1:0] start_base = '0;
  logic [WIDTH-1:0] start_step = '0;
  logic             enq__ENA;
  logic [WIDTH-1:0] enq_v;
  logic             enq__RDY = 1'b1;
  logic             ind__ENA = 1'b0;
  logic [WIDTH-1:0] ind_v = '0;
  logic             ind__RDY;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] recv_count;

  always #5 CLK = ~CLK;

  echo_test_driver #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .start__ENA(start__ENA), .start__RDY(start__RDY),
    .start_count(start_count), .start_base(start_base), .start_step(start_step),
    .enq__ENA(enq__ENA), .enq_v(enq_v), .enq__RDY(enq__RDY),
    .ind__ENA(ind__ENA), .ind_v(ind_v), .ind__RDY(ind__RDY),
    .done(done), .timed_out(timed_out),
    .err_count(err_count), .recv_count(recv_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Echo model: loopback with one cycle of latency, optional hold,
  // truncation after echo_limit values and corruption of one value.
  logic [WIDTH-1:0] echo_q[$];
  logic [WIDTH-1:0] sent_log[$];
  bit               echo_en = 1'b1;
  bit               echo_hold = 1'b0;
  int               echo_limit = 1000;
  int               corrupt_idx = -1;
  logic [WIDTH-1:0] corrupt_val = 32'd5;
  logic             man_ena = 1'b0;
  logic [WIDTH-1:0] man_v = '0;
  int               ecnt = 0, last_ind = 0, n_fired = 0, outst = 0, max_outst = 0;

  always @(posedge CLK) begin
    ecnt++;
    if (nRST) begin
      if (ind__ENA && ind__RDY) begin
        last_ind = ecnt;
        if (outst > 0) outst--;
      end
      if (enq__ENA && enq__RDY) begin
        sent_log.push_back(enq_v);
        if (n_fired < echo_limit)
          echo_q.push_back((n_fired == corrupt_idx) ? corrupt_val : enq_v);
        n_fired++;
        outst++;
        if (outst > max_outst) max_outst = outst;
      end
    end
  end

  always @(negedge CLK) begin
    if (!echo_en) begin
      ind__ENA = man_ena;
      ind_v    = man_v;
    end else if (!echo_hold && echo_q.size() > 0) begin
      ind__ENA = 1'b1;
      ind_v    = echo_q.pop_front();
    end else begin
      ind__ENA = 1'b0;
      ind_v    = '0;
    end
  end

  task automatic do_start(input logic [CNT_W-1:0] c, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] s);
    @(posedge CLK); #1;
    echo_q.delete();
    sent_log.delete();
    n_fired = 0; outst = 0; max_outst = 0;
    start_count = c; start_base = b; start_step = s; start__ENA = 1'b1;
    chk("start_rdy", start__RDY, 1'b1);
    @(posedge CLK); #1;
    start__ENA = 1'b0;
  endtask

  task automatic wait_done(output int waited, output bit ok);
    waited = 0; ok = 1'b0;
    while (waited < 300) begin
      @(negedge CLK);
      if (done) begin ok = 1'b1; break; end
      waited++;
    end
  endtask

  task automatic check_sent(input string nm, input int cnt,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] e;
    e = b;
    chk({nm, "_nsent"}, sent_log.size(), cnt);
    for (int j = 0; j < sent_log.size() && j < cnt; j++) begin
      chk({nm, "_val"}, sent_log[j], e);
      e = e + s;
    end
  endtask

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] step;
    int               corrupt;
    int               limit;
    int               exp_err;
    int               exp_recv;
    bit               exp_to;
  } vec_t;

  vec_t vt[5];

  initial begin
    int  w;
    bit  ok;

    vt[0] = '{16'd4, 32'd22,          32'd1,          -1, 1000, 0, 4, 1'b0};
    vt[1] = '{16'd4, 32'hFFFF_FFFE,   32'd1,           2, 1000, 1, 4, 1'b0};
    vt[2] = '{16'd3, 32'd100,         32'd7,          -1,    2, 0, 2, 1'b1};
    vt[3] = '{16'd6, 32'd5,           32'hFFFF_FFFF,  -1, 1000, 0, 6, 1'b0};
    vt[4] = '{16'd0, 32'd9,           32'd9,          -1, 1000, 0, 0, 1'b0};

    // Reset state
    #1 nRST = 1'b0;
    #2;
    chk("rst_start_rdy", start__RDY, 1'b1);
    chk("rst_enq_ena",   enq__ENA,   1'b0);
    chk("rst_enq_v",     enq_v,      32'd0);
    chk("rst_ind_rdy",   ind__RDY,   1'b0);
    chk("rst_done",      done,       1'b0);
    chk("rst_timed_out", timed_out,  1'b0);
    chk("rst_err",       err_count,  16'd0);
    chk("rst_recv",      recv_count, 16'd0);
    @(posedge CLK); #1 nRST = 1'b1;

    // Table-driven runs
    for (int i = 0; i < 5; i++) begin
      corrupt_idx = vt[i].corrupt;
      echo_limit  = vt[i].limit;
      do_start(vt[i].cnt, vt[i].base, vt[i].step);
      wait_done(w, ok);
      chk("done_seen", ok, 1'b1);
      chk("err_count", err_count, vt[i].exp_err);
      chk("recv_count", recv_count, vt[i].exp_recv);
      chk("timed_out", timed_out, vt[i].exp_to);
      check_sent("seq", vt[i].cnt, vt[i].base, vt[i].step);
      if (vt[i].cnt == 0) chk("zero_cnt_latency", w, 0);
      if (vt[i].exp_to) chk("timeout_gap", ecnt - last_ind, TIMEOUT);
      @(negedge CLK);
      chk("done_one_cycle", done, 1'b0);
      chk("done_hold_rdy", start__RDY, 1'b1);
    end
    corrupt_idx = -1;
    echo_limit  = 1000;

    // Window: echoes withheld, only MAX_OUT values go out
    echo_hold = 1'b1;
    do_start(16'd10, 32'd0, 32'd3);
    repeat (20) @(negedge CLK);
    chk("win_sent_held", n_fired, MAX_OUT);
    chk("win_enq_off", enq__ENA, 1'b0);
    chk("win_recv_zero", recv_count, 16'd0);
    // start while busy is ignored
    @(posedge CLK); #1 start_count = '0; start__ENA = 1'b1;
    @(posedge CLK); #1 start__ENA = 1'b0;
    @(negedge CLK);
    chk("busy_start_no_done", done, 1'b0);
    chk("busy_start_rdy", start__RDY, 1'b0);
    @(posedge CLK); #1 echo_hold = 1'b0;
    wait_done(w, ok);
    chk("win_done", ok, 1'b1);
    chk("win_err", err_count, 16'd0);
    chk("win_recv", recv_count, 16'd10);
    chk("win_max_out", max_outst, MAX_OUT);
    check_sent("win", 10, 32'd0, 32'd3);

    // Unsolicited indication while nothing is outstanding
    echo_en = 1'b0; enq__RDY = 1'b0;
    do_start(16'd2, 32'd50, 32'd10);
    @(negedge CLK);
    chk("uns_enq_req", enq__ENA, 1'b1);
    @(posedge CLK); #1 man_ena = 1'b1; man_v = 32'd77;
    @(posedge CLK); #1 man_ena = 1'b0;
    @(negedge CLK);
    chk("uns_err", err_count, 16'd1);
    chk("uns_recv", recv_count, 16'd0);
    chk("uns_nsent", n_fired, 0);
    @(posedge CLK); #1 echo_en = 1'b1; enq__RDY = 1'b1;
    wait_done(w, ok);
    chk("uns_done", ok, 1'b1);
    chk("uns_err_final", err_count, 16'd1);
    chk("uns_recv_final", recv_count, 16'd2);

    // Asynchronous reset in the middle of a run
    do_start(16'd10, 32'd1000, 32'd1);
    repeat (6) @(negedge CLK);
    chk("pre_rst_recv", recv_count, 16'd4);
    #2 nRST = 1'b0;
    #1;
    chk("arst_enq_ena", enq__ENA, 1'b0);
    chk("arst_ind_rdy", ind__RDY, 1'b0);
    chk("arst_recv", recv_count, 16'd0);
    chk("arst_err", err_count, 16'd0);
    chk("arst_enq_v", enq_v, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    echo_en = 1'b0; man_ena = 1'b1; man_v = 32'd1234;
    @(negedge CLK);
    chk("post_rst_start_rdy", start__RDY, 1'b1);
    chk("post_rst_ind_rdy", ind__RDY, 1'b0);
    repeat (2) @(posedge CLK);
    #1 man_ena = 1'b0;
    @(negedge CLK);
    chk("post_rst_drop_recv", recv_count, 16'd0);
    chk("post_rst_drop_err", err_count, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
